apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB initiator (requester) that turns a valid/ready command stream into single APB3 transfers and returns each result on a valid/ready response stream.
- It is the requester-side counterpart to the APB-slave memories: InputMem at 0x43C0_xxxx and OutputMem at 0x43C2_xxxx.
- It replaces hand-coded APB tasks in benches and fronts the memories from a control FSM or CPU-side bridge.
- One transfer is outstanding at a time; every transfer completes with a response, including error and timeout cases.

Parameters:
- ADDR_W, 32: width of cmd_addr and paddr.
- DATA_W, 32: width of cmd_wdata, pwdata, prdata and rsp_rdata.
- TIMEOUT, 256: number of ACCESS cycles without pready before the transfer is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_slverr  out  1  pslverr sampled at completion
- rsp_timeout  out  1  transfer aborted by timeout
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Behaviour:
- All outputs are registered. While rstn=1 every output is forced to 0 asynchronously, including cmd_ready. State goes to IDLE and the timeout counter clears. The block resumes in IDLE on the first clk after rstn=0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, wdata and write into paddr, pwdata and pwrite, then go to SETUP.
  - cmd_ready falls in the same edge.
- SETUP (exactly 1 cycle): psel=1, penable=0, go to ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata are held stable.
- ACCESS completion: on a clk edge with pready=1:
  - capture rsp_rdata = pwrite ? 0 : prdata;
  - capture rsp_slverr = pslverr and rsp_timeout=0;
  - drop psel, penable and pwrite to 0; paddr and pwdata clear to 0;
  - set rsp_valid=1 and go to RESP.
- ACCESS wait: while pready=0, increment the wait counter. When TIMEOUT!=0 and the count reaches TIMEOUT, abort:
  - drop psel and penable;
  - set rsp_timeout=1, rsp_slverr=0, rsp_rdata=0;
  - go to RESP.
- pready and pslverr are ignored outside ACCESS.
- RESP:
  - rsp_valid held high with stable data until rsp_ready=1, then rsp_valid=0 and go to IDLE (cmd_ready=1 the next cycle).
  - rsp_ready already high on the first RESP cycle gives a one-cycle rsp_valid pulse.
- Latency, zero-wait slave, cmd handshake at edge E:
  - SETUP in cycle E..E+1, ACCESS in E+1..E+2;
  - completion at edge E+2, rsp_valid visible after E+2;
  - next command accepted no earlier than E+4 with rsp_ready=1. Peak throughput is 1 transfer per 4 cycles.
- Each wait state adds one ACCESS cycle.
- psel never rises without penable=0 in the preceding cycle, and penable is never high without psel.
- Commands presented while busy are not accepted; cmd_ready stays 0 from acceptance until RESP exits.
- Timeout counter: $clog2(TIMEOUT+1) bits, cleared on entry to SETUP.
- Reset during ACCESS drops the bus immediately and produces no response for the interrupted transfer.

Test Plan:
- Write, zero wait: cmd write addr 0x43C0_0004 data 0x0000_187D, pready tied 1, rsp_ready=1.
  - psel is seen with penable=0 for 1 cycle, then with penable=1 for 1 cycle.
  - paddr and pwdata are stable throughout.
  - rsp_valid follows 1 cycle later with slverr=0, timeout=0, rdata=0.
- Read, 3 wait states: read 0x43C2_0000, slave holds pready=0 for 3 ACCESS cycles then pready=1 with prdata 0x1234_5678.
  - ACCESS lasts 4 cycles.
  - rsp_rdata = 0x1234_5678.
  - cmd_ready stays 0 throughout.
- Slave error: write with pready=1 and pslverr=1 → rsp_slverr=1. The next command is accepted normally.
- Timeout, TIMEOUT=16: pready held 0 → after exactly 16 ACCESS cycles psel and penable drop, and rsp_timeout=1, rsp_slverr=0.
- Back-pressure: rsp_ready=0 for 10 cycles after a read completes.
  - rsp_valid and rsp_rdata stay stable.
  - cmd_ready stays 0.
  - After rsp_ready=1 and one cycle, cmd_ready=1.
  - Sixteen back-to-back writes to 0x43C0_0000..0x43C0_003C complete in order, 4 cycles each.
- Reset mid-ACCESS: assert rstn=1 while pready=0 → psel, penable, cmd_ready and rsp_valid are 0 the same cycle. After release, a fresh read completes correctly.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB3 requester: converts a valid/ready command stream into single APB transfers
// and returns each result (data, slave error, timeout) on a valid/ready response stream.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                timeout_hit;

    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_slverr_q;
    logic                rsp_timeout_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;

    // The abort fires on the edge that would complete the TIMEOUT-th idle ACCESS cycle.
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_wdata;
                        pwrite_q    <= cmd_write;
                        psel_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready || timeout_hit) begin
                        rsp_rdata_q   <= (pready && !pwrite_q) ? prdata : '0;
                        rsp_slverr_q  <= pready && pslverr;
                        rsp_timeout_q <= !pready;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        pwrite_q      <= 1'b0;
                        paddr_q       <= '0;
                        pwdata_q      <= '0;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;
    assign paddr       = paddr_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: table of transfers against a scripted APB slave,
// plus hand-written reset sequences.
module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr, rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            bp;
        logic [DW-1:0] exp_rdata;
        logic          exp_slverr;
        logic          exp_timeout;
        int            exp_acc;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus protocol monitor: penable only with psel, psel rises only in a setup phase.
    logic psel_prev = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            chk("penable_without_psel", {63'b0, penable & ~psel}, 64'd0);
            if (psel && !psel_prev) chk("psel_rise_penable", {63'b0, penable}, 64'd0);
        end
        psel_prev <= psel;
    end

    task automatic run(input vec_t v, input string tag);
        int guard, acc, cyc;
        bit bad_bus, bad_rdy, bad_hold;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        chk({tag, ".cmd_ready"}, {63'b0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.write ? v.wdata : 32'hBAD0_BAD0;
        rsp_ready = (v.bp == 0);
        step();
        cyc = 1;
        // change the command inputs after acceptance: the bus must keep the latched values
        cmd_valid = 1'b0;
        cmd_write = ~v.write;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        chk({tag, ".setup_psel"}, {63'b0, psel}, 64'd1);
        chk({tag, ".setup_penable"}, {63'b0, penable}, 64'd0);
        chk({tag, ".setup_paddr"}, {32'b0, paddr}, {32'b0, v.addr});
        chk({tag, ".setup_pwrite"}, {63'b0, pwrite}, {63'b0, v.write});
        chk({tag, ".setup_cmd_ready"}, {63'b0, cmd_ready}, 64'd0);
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hFFFF_0000;
        acc = 0; bad_bus = 0; bad_rdy = 0; bad_hold = 0;
        do begin
            step();
            cyc++;
            if (cmd_ready) bad_rdy = 1;
            if (!rsp_valid) begin
                if (!(psel && penable)) bad_bus = 1;
                if (paddr !== v.addr || pwrite !== v.write) bad_bus = 1;
                if (v.write && pwdata !== v.wdata) bad_bus = 1;
                acc++;
                pready  = (acc > v.waits);
                pslverr = v.slverr;
                prdata  = v.prdata;
            end
        end while (!rsp_valid && cyc < 300);
        pready  = 1'b0;
        pslverr = 1'b0;
        chk({tag, ".rsp_valid"}, {63'b0, rsp_valid}, 64'd1);
        chk({tag, ".rsp_rdata"}, {32'b0, rsp_rdata}, {32'b0, v.exp_rdata});
        chk({tag, ".rsp_slverr"}, {63'b0, rsp_slverr}, {63'b0, v.exp_slverr});
        chk({tag, ".rsp_timeout"}, {63'b0, rsp_timeout}, {63'b0, v.exp_timeout});
        chk({tag, ".bus_idle"}, {61'b0, psel, penable, pwrite}, 64'd0);
        chk({tag, ".access_cycles"}, 64'(acc), 64'(v.exp_acc));
        for (int i = 0; i < v.bp; i++) begin
            step();
            cyc++;
            if (!rsp_valid || rsp_rdata !== v.exp_rdata || rsp_timeout !== v.exp_timeout) bad_hold = 1;
            if (cmd_ready) bad_rdy = 1;
        end
        rsp_ready = 1'b1;
        step();
        cyc++;
        chk({tag, ".rsp_drop"}, {63'b0, rsp_valid}, 64'd0);
        chk({tag, ".ready_back"}, {63'b0, cmd_ready}, 64'd1);
        chk({tag, ".cycles"}, 64'(cyc), 64'(v.exp_acc + v.bp + 3));
        chk({tag, ".bus_stable"}, {63'b0, bad_bus}, 64'd0);
        chk({tag, ".busy_not_ready"}, {63'b0, bad_rdy}, 64'd0);
        chk({tag, ".rsp_held"}, {63'b0, bad_hold}, 64'd0);
    endtask

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input int w, input logic [DW-1:0] rd, input logic se, input int bp,
                                input logic [DW-1:0] er, input logic es, input logic et, input int ea);
        vec_t v;
        v.write = wr; v.addr = a; v.wdata = wd; v.waits = w; v.prdata = rd; v.slverr = se;
        v.bp = bp; v.exp_rdata = er; v.exp_slverr = es; v.exp_timeout = et; v.exp_acc = ea;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(1, 32'h43C0_0004, 32'h0000_187D, 0,    32'hAAAA_5555, 0, 0,  32'h0,         0, 0, 1);
        vecs[1] = mk(0, 32'h43C2_0000, 32'h0,         3,    32'h1234_5678, 0, 0,  32'h1234_5678, 0, 0, 4);
        vecs[2] = mk(1, 32'h43C0_0010, 32'hCAFE_0001, 0,    32'h0,         1, 0,  32'h0,         1, 0, 1);
        vecs[3] = mk(1, 32'h43C0_0008, 32'h0BAD_F00D, 1,    32'h0,         0, 0,  32'h0,         0, 0, 2);
        vecs[4] = mk(0, 32'h43C2_0004, 32'h0,         1000, 32'h5A5A_5A5A, 1, 0,  32'h0,         0, 1, TO);
        vecs[5] = mk(0, 32'h43C2_0010, 32'h0,         0,    32'hDEAD_BEEF, 0, 10, 32'hDEAD_BEEF, 0, 0, 1);
        vecs[6] = mk(0, 32'h43C2_0020, 32'h0,         TO-1, 32'h0F0F_1234, 0, 0,  32'h0F0F_1234, 0, 0, TO);
        for (int i = 0; i < 16; i++)
            vecs[7+i] = mk(1, 32'h43C0_0000 + 32'(4*i), 32'h1000_0000 + 32'(i), 0, 32'h0, 0, 0,
                           32'h0, 0, 0, 1);

        rstn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #3;
        chk("reset_outputs", {58'b0, cmd_ready, rsp_valid, psel, penable, pwrite, rsp_timeout}, 64'd0);
        chk("reset_paddr", {32'b0, paddr}, 64'd0);
        step();
        step();
        rstn = 1'b0;
        step();
        chk("post_reset_ready", {63'b0, cmd_ready}, 64'd1);

        for (int i = 0; i < NV; i++) run(vecs[i], $sformatf("v%0d", i));

        // Reset while a read is stalled in ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h43C2_0030; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0; pready = 1'b0;
        step();
        step();
        chk("mid_access", {62'b0, psel, penable}, 64'd3);
        #2 rstn = 1'b1;
        #1;
        chk("async_reset_bus", {60'b0, psel, penable, cmd_ready, rsp_valid}, 64'd0);
        chk("async_reset_paddr", {32'b0, paddr}, 64'd0);
        step();
        rstn = 1'b0;
        step();
        chk("resume_ready", {63'b0, cmd_ready}, 64'd1);
        chk("no_orphan_rsp", {63'b0, rsp_valid}, 64'd0);
        run(mk(0, 32'h43C2_0040, 32'h0, 2, 32'h7654_3210, 0, 0, 32'h7654_3210, 0, 0, 3), "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
